z_writeback: RTL

Downstream stage of the ALU: accepts the 64-bit ALU result (reg_C) and the 5-bit Control code with a valid/ready handshake, and latches the result into the Z register. It then serialises Z onto the 32-bit datapath bus as one beat (ordinary ops) or two beats (MUL/DIV), and updates the architectural HI/LO registers for MUL/DIV. It also produces zero/negative flags for the branch/condition logic.

---
 rtl/z_writeback.sv | 135 +++++++++++++
 1 files changed

// File: rtl/z_writeback.sv
// Writeback stage: latches the 64-bit ALU result into Z, drains it onto the
// 32-bit bus as one or two beats, and updates HI/LO for multiply/divide.
module z_writeback #(
  parameter int         DATA_W = 32,
  parameter logic [4:0] OP_MUL = 5'b01110,
  parameter logic [4:0] OP_DIV = 5'b01111
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic [4:0]            Control,
  input  logic [2*DATA_W-1:0]   reg_C,
  input  logic                  c_valid,
  output logic                  c_ready,
  output logic [DATA_W-1:0]     bus_out,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_sel,
  output logic [DATA_W-1:0]     lo_out,
  output logic [DATA_W-1:0]     hi_out,
  output logic                  z_zero,
  output logic                  z_neg,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [4:0]          op_q, op_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;

  logic in_wide;
  logic op_wide;

  assign in_wide = (Control == OP_MUL) || (Control == OP_DIV);
  assign op_wide = (op_q == OP_MUL) || (op_q == OP_DIV);

  // Outputs depend on registered state only, never on c_valid or bus_ready.
  always_comb begin
    c_ready   = 1'b0;
    bus_valid = 1'b0;
    bus_sel   = 1'b0;
    bus_out   = '0;
    busy      = 1'b0;
    case (state_q)
      S_LO: begin
        bus_valid = 1'b1;
        busy      = 1'b1;
        bus_out   = z_q[DATA_W-1:0];
      end
      S_HI: begin
        bus_valid = 1'b1;
        busy      = 1'b1;
        bus_sel   = 1'b1;
        bus_out   = z_q[2*DATA_W-1:DATA_W];
      end
      default: c_ready = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    op_d    = op_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      S_LO: begin
        if (bus_ready) begin
          if (op_wide) begin
            lo_d    = z_q[DATA_W-1:0];
            state_d = S_HI;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HI: begin
        if (bus_ready) begin
          hi_d    = z_q[2*DATA_W-1:DATA_W];
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (c_valid) begin
          z_d     = reg_C;
          op_d    = Control;
          state_d = S_LO;
          // Flag width follows the op: full 64 bits for MUL/DIV, low word otherwise.
          if (in_wide) begin
            zero_d = (reg_C == '0);
            neg_d  = reg_C[2*DATA_W-1];
          end else begin
            zero_d = (reg_C[DATA_W-1:0] == '0);
            neg_d  = reg_C[DATA_W-1];
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      op_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign lo_out = lo_q;
  assign hi_out = hi_q;
  assign z_zero = zero_q;
  assign z_neg  = neg_q;

endmodule
